// File: rtl/jk_drv_pkg.sv
// Shared types and constants for the JK excitation driver family.
package jk_drv_pkg;

  // Driver FSM states; encoding is fixed so debug probes can decode it.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StCheck = 2'd2,
    StFin   = 2'd3
  } drv_state_e;

  // Don't-care resolution for excitation outputs.
  localparam int unsigned DcZero = 0;  // set/reset style
  localparam int unsigned DcOne  = 1;  // toggle style

endpackage

// File: rtl/jk_excitation_lut.sv
// Combinational JK excitation table: which (J,K) moves the flop from q to d.
// Don't-care entries resolve to mode_i, so the outputs are never X.
module jk_excitation_lut (
  input  logic q_i,
  input  logic d_i,
  input  logic mode_i,
  output logic j_o,
  output logic k_o
);

  // q=0 only J matters (set when d=1); q=1 only K matters (clear when d=0).
  always_comb begin
    j_o = 1'b0;
    k_o = 1'b0;
    if (q_i) begin
      j_o = mode_i;
      k_o = ~d_i;
    end else begin
      j_o = d_i;
      k_o = mode_i;
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK flop so its q follows a captured pattern LSB first, then checks
// q one cycle after each drive and counts mismatches (saturating).
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int unsigned PAT_W   = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned DC_MODE = DcZero
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             err
);

  localparam int unsigned IdxW    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic ModeBit = (DC_MODE == DcOne);

  drv_state_e       state_q;
  logic [PAT_W-1:0] shift_q;
  logic [IdxW-1:0]  idx_q;
  logic             exp_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             lut_j;
  logic             lut_k;
  logic             cmp_en;
  logic             miss;

  // Current target bit is always the LSB of the shift register.
  jk_excitation_lut u_lut (
    .q_i    (q_fb),
    .d_i    (shift_q[0]),
    .mode_i (ModeBit),
    .j_o    (lut_j),
    .k_o    (lut_k)
  );

  // Excitation only in DRIVE; elsewhere j=k=0 so the flop holds.
  always_comb begin
    j = 1'b0;
    k = 1'b0;
    if (state_q == StDrive) begin
      j = lut_j;
      k = lut_k;
    end
  end

  // q_fb reflects the previous drive from the second DRIVE cycle through CHECK.
  always_comb begin
    cmp_en = ((state_q == StDrive) && (idx_q != '0)) || (state_q == StCheck);
    miss   = cmp_en && (q_fb != exp_q);
    cnt_d  = cnt_q;
    if (miss && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // FSM, pattern shifter, expected bit and mismatch counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      exp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            shift_q <= pattern;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StDrive;
          end
        end
        StDrive: begin
          shift_q <= shift_q >> 1;
          exp_q   <= shift_q[0];
          idx_q   <= idx_q + 1'b1;
          cnt_q   <= cnt_d;
          err_q   <= |cnt_d;
          if (idx_q == LastIdx) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          cnt_q   <= cnt_d;
          err_q   <= |cnt_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StFin;
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mismatch_cnt = cnt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench: three drivers (DC_MODE=0, DC_MODE=1, CNT_W=3) each with a JK flop
// model on its feedback, or a stuck/random q_fb, checked against a run model.
module tb_jk_excitation_driver;

  localparam int unsigned PatW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [2:0] q_fb;
  logic [2:0] j;
  logic [2:0] k;
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] err;
  logic [2:0] fq;
  logic [3:0] cnt [3];
  logic [2:0] cnt2_w;
  int         fb_mode = 0;  // 0 flop, 1 stuck-0, 2 stuck-1, 3 random
  logic       rnd_q = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         tog;

  always #5 clk = ~clk;

  jk_excitation_driver #(.PAT_W(PatW), .CNT_W(4), .DC_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .q_fb(q_fb[0]),
    .j(j[0]), .k(k[0]), .busy(busy[0]), .done(done[0]), .mismatch_cnt(cnt[0]), .err(err[0])
  );
  jk_excitation_driver #(.PAT_W(PatW), .CNT_W(4), .DC_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .q_fb(q_fb[1]),
    .j(j[1]), .k(k[1]), .busy(busy[1]), .done(done[1]), .mismatch_cnt(cnt[1]), .err(err[1])
  );
  jk_excitation_driver #(.PAT_W(PatW), .CNT_W(3), .DC_MODE(0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .q_fb(q_fb[2]),
    .j(j[2]), .k(k[2]), .busy(busy[2]), .done(done[2]), .mismatch_cnt(cnt2_w), .err(err[2])
  );
  assign cnt[2] = {1'b0, cnt2_w};

  // Behavioural JK flops sharing clock and reset with the drivers.
  always @(posedge clk or posedge rst) begin
    if (rst) fq <= '0;
    else begin
      for (int n = 0; n < 3; n++) begin
        case ({j[n], k[n]})
          2'b01:   fq[n] <= 1'b0;
          2'b10:   fq[n] <= 1'b1;
          2'b11:   fq[n] <= ~fq[n];
          default: fq[n] <= fq[n];
        endcase
      end
    end
  end

  always_comb begin
    q_fb = fq;
    for (int n = 0; n < 3; n++) begin
      if (fb_mode == 1) q_fb[n] = 1'b0;
      else if (fb_mode == 2) q_fb[n] = 1'b1;
      else if (fb_mode == 3) q_fb[n] = rnd_q;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Excitation table returning {J,K}; don't-care takes dc.
  function automatic logic [1:0] excite(input logic q, input logic d, input logic dc);
    case ({q, d})
      2'b00:   return {1'b0, dc};
      2'b01:   return {1'b1, dc};
      2'b10:   return {dc, 1'b1};
      default: return {dc, 1'b0};
    endcase
  endfunction

  function automatic int sat(input int m, input int n);
    int lim;
    lim = (n == 2) ? 7 : 15;
    return (m > lim) ? lim : m;
  endfunction

  task automatic check_idle_zero(input string tag);
    for (int n = 0; n < 3; n++) begin
      check_eq($sformatf("%s busy%0d", tag, n), busy[n], 0);
      check_eq($sformatf("%s done%0d", tag, n), done[n], 0);
      check_eq($sformatf("%s j%0d", tag, n), j[n], 0);
      check_eq($sformatf("%s k%0d", tag, n), k[n], 0);
      check_eq($sformatf("%s cnt%0d", tag, n), cnt[n], 0);
      check_eq($sformatf("%s err%0d", tag, n), err[n], 0);
    end
  endtask

  // One run: cycle c is the cycle after the c-th edge following the start edge.
  task automatic run(input logic [7:0] pat, input int fbm, input bit restart,
                     input int rst_cyc, output int tog_o);
    int         miss [3];
    logic [1:0] jk;
    miss  = '{0, 0, 0};
    tog_o = 0;
    @(negedge clk);
    fb_mode = fbm;
    pattern = pat;
    start   = 1'b1;
    for (int c = 0; c <= PatW + 1; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (restart && c == 3) begin
        start   = 1'b1;
        pattern = 8'h55;
      end
      if (restart && c == 4) start = 1'b0;
      if (fbm == 3) rnd_q = 1'($urandom);
      if (c == rst_cyc) begin
        rst = 1'b1;
        #1;
        check_idle_zero("midrst");
        #1 rst = 1'b0;
        for (int w = 0; w < PatW + 4; w++) begin
          @(negedge clk);
          #1;
          for (int n = 0; n < 3; n++) begin
            check_eq($sformatf("postrst done%0d", n), done[n], 0);
            check_eq($sformatf("postrst busy%0d", n), busy[n], 0);
          end
        end
        return;
      end
      #1;
      for (int n = 0; n < 3; n++) begin
        if (c == 0) begin
          check_eq($sformatf("clr cnt%0d", n), cnt[n], 0);
          check_eq($sformatf("clr err%0d", n), err[n], 0);
        end
        if (c < PatW) begin
          jk = excite(q_fb[n], pat[c], n == 1);
          check_eq($sformatf("j%0d c%0d", n, c), j[n], jk[1]);
          check_eq($sformatf("k%0d c%0d", n, c), k[n], jk[0]);
          check_eq($sformatf("busy%0d c%0d", n, c), busy[n], 1);
          check_eq($sformatf("done%0d c%0d", n, c), done[n], 0);
          if (n == 1 && j[1] && k[1]) tog_o++;
        end else if (c == PatW) begin
          check_eq($sformatf("chk j%0d", n), j[n], 0);
          check_eq($sformatf("chk k%0d", n), k[n], 0);
          check_eq($sformatf("chk busy%0d", n), busy[n], 1);
          check_eq($sformatf("chk done%0d", n), done[n], 0);
        end else begin
          check_eq($sformatf("fin done%0d", n), done[n], 1);
          check_eq($sformatf("fin busy%0d", n), busy[n], 0);
          check_eq($sformatf("fin cnt%0d", n), cnt[n], sat(miss[n], n));
          check_eq($sformatf("fin err%0d", n), err[n], miss[n] != 0);
        end
        if (c >= 1 && c <= PatW) begin
          if (q_fb[n] != pat[c-1]) miss[n]++;
          if (fbm == 0) check_eq($sformatf("follow q%0d c%0d", n, c), q_fb[n], pat[c-1]);
        end
      end
    end
    @(negedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      check_eq($sformatf("idle done%0d", n), done[n], 0);
      check_eq($sformatf("idle j%0d", n), j[n], 0);
      check_eq($sformatf("idle k%0d", n), k[n], 0);
      check_eq($sformatf("idle cnt%0d", n), cnt[n], sat(miss[n], n));
      check_eq($sformatf("idle err%0d", n), err[n], miss[n] != 0);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;

    run(8'b1011_0010, 0, 1'b0, -1, tog);
    check_eq("dc1 toggle cycles>=5", tog >= 5, 1);
    run(8'hFF, 1, 1'b0, -1, tog);
    run(8'h00, 2, 1'b0, -1, tog);
    run(8'b1011_0010, 0, 1'b1, -1, tog);
    run(8'h55, 0, 1'b0, -1, tog);
    run(8'b1011_0010, 0, 1'b0, 3, tog);
    run(8'b1011_0010, 0, 1'b0, -1, tog);
    for (int r = 0; r < 12; r++) begin
      run(8'($urandom), int'($urandom_range(0, 3)), 1'b0, -1, tog);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
